// File: rtl/mig_app_arbiter.sv
// Two-requester arbiter in front of a MIG UI port; a read-tag FIFO routes read returns back to their requester.
// Build option: define MIG_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins), otherwise round-robin.
module mig_app_arbiter #(
  parameter  int ADDR_WIDTH     = 28,
  parameter  int APP_DATA_WIDTH = 128,
  parameter  int TAG_DEPTH      = 16,
  localparam int APP_MASK_WIDTH = APP_DATA_WIDTH / 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        init_calib_complete,
  input  logic [1:0]                  req_valid,
  input  logic [5:0]                  req_cmd,
  input  logic [2*ADDR_WIDTH-1:0]     req_addr,
  input  logic [2*APP_DATA_WIDTH-1:0] req_wdata,
  input  logic [2*APP_MASK_WIDTH-1:0] req_wmask,
  output logic [1:0]                  req_ready,
  output logic [APP_DATA_WIDTH-1:0]   rsp_data,
  output logic [1:0]                  rsp_valid,
  output logic [ADDR_WIDTH-1:0]       app_addr,
  output logic [2:0]                  app_cmd,
  output logic                        app_en,
  output logic [APP_DATA_WIDTH-1:0]   app_wdf_data,
  output logic [APP_MASK_WIDTH-1:0]   app_wdf_mask,
  output logic                        app_wdf_wren,
  output logic                        app_wdf_end,
  input  logic                        app_rdy,
  input  logic                        app_wdf_rdy,
  input  logic [APP_DATA_WIDTH-1:0]   app_rd_data,
  input  logic                        app_rd_data_valid,
  output logic                        busy,
  output logic                        err
);
  localparam logic [1:0] S_WAIT_CAL = 2'd0;
  localparam logic [1:0] S_IDLE     = 2'd1;
  localparam logic [1:0] S_ISSUE    = 2'd2;
  localparam logic [2:0] CMD_WRITE  = 3'b000;
  localparam logic [2:0] CMD_READ   = 3'b001;
  localparam int         PTR_W      = $clog2(TAG_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [1:0]                r_state;
  logic [2:0]                r_cmd;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [APP_DATA_WIDTH-1:0] r_wdata;
  logic [APP_MASK_WIDTH-1:0] r_wmask;
  logic                      r_id;
  logic                      r_cmd_done;
  logic                      r_wdf_done;
  logic                      r_err;
  logic [1:0]                r_rsp_valid;
  logic [APP_DATA_WIDTH-1:0] r_rsp_data;
  logic                      r_tag_mem [TAG_DEPTH];
  logic [PTR_W:0]            r_wr_ptr;
  logic [PTR_W:0]            r_rd_ptr;
`ifndef MIG_ARB_FIXED_PRIO_EN
  logic                      r_last;
`endif

  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [1:0]                w_elig;
  logic                      w_gnt_id;
  logic                      w_grant;
  logic [2:0]                w_sel_cmd;
  logic                      w_issue;
  logic                      w_is_write;
  logic                      w_cmd_hs;
  logic                      w_wdf_hs;
  logic                      w_cmd_fin;
  logic                      w_wdf_fin;
  logic                      w_push;

  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                        (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

  // A read may only be granted while a tag slot is free; other commands never wait on the FIFO.
  for (genvar gi = 0; gi < 2; gi++) begin : g_elig
    assign w_elig[gi] = req_valid[gi] && !((req_cmd[3*gi +: 3] == CMD_READ) && w_fifo_full);
  end

`ifdef MIG_ARB_FIXED_PRIO_EN
  assign w_gnt_id = !w_elig[0];
`else
  assign w_gnt_id = (w_elig == 2'b11) ? !r_last : !w_elig[0];
`endif

  assign w_grant   = !rst && (r_state == S_IDLE) && init_calib_complete && (w_elig != 2'b00);
  assign w_sel_cmd = w_gnt_id ? req_cmd[5:3] : req_cmd[2:0];
  assign req_ready = w_grant ? (2'b01 << w_gnt_id) : 2'b00;

  assign w_issue    = !rst && (r_state == S_ISSUE);
  assign w_is_write = (r_cmd == CMD_WRITE);
  assign app_en       = w_issue && !r_cmd_done;
  assign app_wdf_wren = w_issue && w_is_write && !r_wdf_done;
  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = (w_issue && w_is_write) ? r_wdata : '0;
  assign app_wdf_mask = (w_issue && w_is_write) ? r_wmask : '0;
  assign app_cmd      = r_cmd;
  assign app_addr     = r_addr;

  assign w_cmd_hs  = app_en && app_rdy;
  assign w_wdf_hs  = app_wdf_wren && app_wdf_rdy;
  assign w_cmd_fin = r_cmd_done || w_cmd_hs;
  assign w_wdf_fin = r_wdf_done || w_wdf_hs || !w_is_write;
  assign w_push    = w_cmd_hs && (r_cmd == CMD_READ);

  assign busy      = (r_state == S_ISSUE);
  assign err       = r_err;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  always_ff @(posedge clk) begin
    if (w_push) r_tag_mem[r_wr_ptr[PTR_W-1:0]] <= r_id;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_WAIT_CAL;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_id        <= 1'b0;
      r_cmd_done  <= 1'b0;
      r_wdf_done  <= 1'b0;
      r_err       <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_rsp_data  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
`ifndef MIG_ARB_FIXED_PRIO_EN
      r_last      <= 1'b1;
`endif
    end else begin
      r_rsp_valid <= 2'b00;
      case (r_state)
        S_WAIT_CAL: if (init_calib_complete) r_state <= S_IDLE;
        S_IDLE: begin
          if (!init_calib_complete) begin
            r_state <= S_WAIT_CAL;
          end else if (w_grant) begin
            r_cmd      <= w_sel_cmd;
            r_addr     <= w_gnt_id ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
            r_wdata    <= w_gnt_id ? req_wdata[2*APP_DATA_WIDTH-1:APP_DATA_WIDTH] : req_wdata[APP_DATA_WIDTH-1:0];
            r_wmask    <= w_gnt_id ? req_wmask[2*APP_MASK_WIDTH-1:APP_MASK_WIDTH] : req_wmask[APP_MASK_WIDTH-1:0];
            r_id       <= w_gnt_id;
            r_cmd_done <= 1'b0;
            r_wdf_done <= 1'b0;
`ifndef MIG_ARB_FIXED_PRIO_EN
            r_last     <= w_gnt_id;
`endif
            // Unknown commands are consumed but never reach the MIG.
            if (w_sel_cmd == CMD_WRITE || w_sel_cmd == CMD_READ) r_state <= S_ISSUE;
            else r_err <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (w_cmd_hs) r_cmd_done <= 1'b1;
          if (w_wdf_hs) r_wdf_done <= 1'b1;
          if (w_cmd_fin && w_wdf_fin) r_state <= init_calib_complete ? S_IDLE : S_WAIT_CAL;
        end
        default: r_state <= S_WAIT_CAL;
      endcase

      if (app_rd_data_valid) begin
        if (w_fifo_empty) begin
          r_err <= 1'b1;
        end else begin
          r_rd_ptr    <= r_rd_ptr + PTR_ONE;
          r_rsp_valid <= 2'b01 << r_tag_mem[r_rd_ptr[PTR_W-1:0]];
          r_rsp_data  <= app_rd_data;
        end
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
    end
  end
endmodule

// File: tb/tb_mig_app_arbiter.sv
// Scoreboard bench for mig_app_arbiter: stimulus pushes expected grants/commands/data/responses, a monitor pops and compares.
module tb_mig_app_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int MW = 16;
  localparam logic [2:0] WR = 3'b000;
  localparam logic [2:0] RD = 3'b001;

  logic            clk = 1'b0;
  logic            rst;
  logic            init_calib_complete;
  logic [1:0]      req_valid;
  logic [5:0]      req_cmd;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [2*MW-1:0] req_wmask;
  logic [1:0]      req_ready;
  logic [DW-1:0]   rsp_data;
  logic [1:0]      rsp_valid;
  logic [AW-1:0]   app_addr;
  logic [2:0]      app_cmd;
  logic            app_en;
  logic [DW-1:0]   app_wdf_data;
  logic [MW-1:0]   app_wdf_mask;
  logic            app_wdf_wren;
  logic            app_wdf_end;
  logic            app_rdy;
  logic            app_wdf_rdy;
  logic [DW-1:0]   app_rd_data;
  logic            app_rd_data_valid;
  logic            busy;
  logic            err;

  mig_app_arbiter dut (
    .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
    .req_valid(req_valid), .req_cmd(req_cmd), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
    .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  logic [1:0]         exp_gnt_q [$];
  logic [AW+2:0]      exp_cmd_q [$];
  logic [DW+MW-1:0]   exp_wdf_q [$];
  logic [DW+1:0]      exp_rsp_q [$];
  int n_tests = 0;
  int n_fail = 0;
  int wren_cycles = 0;
  int busy_cycles = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (app_wdf_wren) wren_cycles++;
        if (busy) busy_cycles++;
        if (req_ready != 2'b00) begin
          if (exp_gnt_q.size() == 0) check("unexpected_grant", 256'(req_ready), 256'(0));
          else check("grant", 256'(req_ready), 256'(exp_gnt_q.pop_front()));
        end
        if (app_en && app_rdy) begin
          if (exp_cmd_q.size() == 0) check("unexpected_cmd", 256'({app_cmd, app_addr}), 256'(0));
          else check("cmd", 256'({app_cmd, app_addr}), 256'(exp_cmd_q.pop_front()));
        end
        if (app_wdf_wren && app_wdf_rdy) begin
          if (exp_wdf_q.size() == 0) check("unexpected_wdf", 256'({app_wdf_mask, app_wdf_data}), 256'(0));
          else check("wdf", 256'({app_wdf_end, app_wdf_mask, app_wdf_data}), 256'({1'b1, exp_wdf_q.pop_front()}));
        end
        if (rsp_valid != 2'b00) begin
          if (exp_rsp_q.size() == 0) check("unexpected_rsp", 256'({rsp_valid, rsp_data}), 256'(0));
          else check("rsp", 256'({rsp_valid, rsp_data}), 256'(exp_rsp_q.pop_front()));
        end
      end
    end
  endtask

  function automatic logic [AW-1:0] mk_addr(input int i, input int k);
    return AW'(32'h1000 * (i + 1) + 32'h40 * k);
  endfunction
  function automatic logic [DW-1:0] mk_data(input int i, input int k);
    return {96'h0, 32'hD000_0000 + 32'(i * 16 + k)};
  endfunction
  function automatic logic [MW-1:0] mk_mask(input int i, input int k);
    return MW'(16'h0100 * (i + 1) + 16'(k));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input int i, input logic [2:0] cmd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [MW-1:0] mask);
    req_valid[i]           = 1'b1;
    req_cmd[3*i +: 3]      = cmd;
    req_addr[AW*i +: AW]   = addr;
    req_wdata[DW*i +: DW]  = data;
    req_wmask[MW*i +: MW]  = mask;
  endtask

  task automatic expect_req(input int i, input logic [2:0] cmd, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input logic [MW-1:0] mask);
    exp_gnt_q.push_back(2'(1 << i));
    if (cmd == WR || cmd == RD) exp_cmd_q.push_back({cmd, addr});
    if (cmd == WR) exp_wdf_q.push_back({mask, data});
  endtask

  task automatic wait_grant(input int i);
    bit got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
    end
    if (!got) check("grant_timeout", 256'(0), 256'(1));
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic do_req(input int i, input logic [2:0] cmd, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [MW-1:0] mask);
    expect_req(i, cmd, addr, data, mask);
    present(i, cmd, addr, data, mask);
    wait_grant(i);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"}, 256'({req_ready, rsp_valid, app_en, app_wdf_wren, app_wdf_end, busy, err}), 256'(0));
    check({name, "_cmd"}, 256'({app_cmd, app_addr, app_wdf_mask}), 256'(0));
    check({name, "_data"}, 256'({rsp_data, app_wdf_data}), 256'(0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic check_queues_empty(input string name);
    check({name, "_queues"}, 256'({exp_gnt_q.size(), exp_cmd_q.size(), exp_wdf_q.size(), exp_rsp_q.size()}), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx [2];
    int order_i [6];
    int order_k [6];
    logic [1:0] r;
    rst = 1'b1; init_calib_complete = 1'b0; req_valid = '0; req_cmd = '0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    app_rd_data = '0; app_rd_data_valid = 1'b0;
    fork
      monitor();
    join_none
    tick(); tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    tick();
    init_calib_complete = 1'b1;
    tick(); tick();

    // Both requesters stream writes back to back.
    for (int n = 0; n < 6; n++) begin
`ifdef MIG_ARB_FIXED_PRIO_EN
      order_i[n] = n / 3; order_k[n] = n % 3;
`else
      order_i[n] = n % 2; order_k[n] = n / 2;
`endif
      expect_req(order_i[n], WR, mk_addr(order_i[n], order_k[n]), mk_data(order_i[n], order_k[n]), mk_mask(order_i[n], order_k[n]));
    end
    busy_cycles = 0;
    idx[0] = 0; idx[1] = 0;
    present(0, WR, mk_addr(0, 0), mk_data(0, 0), mk_mask(0, 0));
    present(1, WR, mk_addr(1, 0), mk_data(1, 0), mk_mask(1, 0));
    for (int c = 0; c < 60 && (idx[0] < 3 || idx[1] < 3); c++) begin
      @(negedge clk);
      r = req_ready;
      tick();
      for (int i = 0; i < 2; i++) begin
        if (r[i]) begin
          idx[i]++;
          if (idx[i] < 3) present(i, WR, mk_addr(i, idx[i]), mk_data(i, idx[i]), mk_mask(i, idx[i]));
          else req_valid[i] = 1'b0;
        end
      end
    end
    check("stream_all_granted", 256'({idx[0], idx[1]}), 256'({32'd3, 32'd3}));
    @(negedge clk); @(negedge clk);
    check("stream_busy_cycles", 256'(busy_cycles), 256'(6));
    check_queues_empty("stream");

    // Write data channel stalls for three cycles after the command is taken.
    tick();
    app_wdf_rdy = 1'b0;
    wren_cycles = 0;
    do_req(0, WR, 28'h0AB_CDE0, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 16'hA5C3);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("stall_wdf_hold", 256'({app_wdf_wren, app_wdf_mask, app_wdf_data}),
            256'({1'b1, 16'hA5C3, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210}));
      tick();
      if (k == 2) app_wdf_rdy = 1'b1;
    end
    @(negedge clk);
    check("stall_done", 256'({busy, app_wdf_wren}), 256'(0));
    check("stall_wren_cycles", 256'(wren_cycles), 256'(4));
    check_queues_empty("stall");

    // Read sequence routed back by tag.
    tick();
    do_req(0, RD, 28'h10, '0, '0);
    do_req(1, RD, 28'h20, '0, '0);
    do_req(0, RD, 28'h30, '0, '0);
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      r = (k == 1) ? 2'b10 : 2'b01;
      exp_rsp_q.push_back({r, DW'(32'hA + k)});
      app_rd_data = DW'(32'hA + k);
      app_rd_data_valid = 1'b1;
      tick();
      app_rd_data_valid = 1'b0;
      @(negedge clk);
      check("read_latency", 256'(rsp_valid), 256'(r));
      tick();
    end
    check_queues_empty("read");

    // Fill the tag FIFO; the next read must wait for a return.
    for (int k = 0; k < 16; k++) do_req(k % 2, RD, AW'(32'h200 + k * 16), '0, '0);
    tick(); tick();
    present(0, RD, 28'h300, '0, '0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("full_no_grant", 256'(req_ready), 256'(0));
      tick();
    end
    expect_req(0, RD, 28'h300, '0, '0);
    exp_rsp_q.push_back({2'b01, DW'(32'hE00)});
    app_rd_data = DW'(32'hE00);
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    wait_grant(0);
    for (int k = 1; k <= 16; k++) begin
      r = (k == 16) ? 2'b01 : ((k % 2 == 1) ? 2'b10 : 2'b01);
      exp_rsp_q.push_back({r, DW'(32'hE00 + k)});
      app_rd_data = DW'(32'hE00 + k);
      app_rd_data_valid = 1'b1;
      tick();
    end
    app_rd_data_valid = 1'b0;
    tick(); tick();
    check_queues_empty("full");
    check("full_no_err", 256'(err), 256'(0));

    // Reset in the middle of ISSUE abandons the write.
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    exp_gnt_q.push_back(2'b10);
    present(1, WR, 28'h777, 128'h55, 16'h1);
    wait_grant(1);
    @(negedge clk);
    check("midissue_app_en", 256'({app_en, app_wdf_wren}), 256'(2'b11));
    tick();
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    pulse_reset();
    @(negedge clk);
    check_reset_outputs("midreset");
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      check("midreset_no_reissue", 256'({app_en, busy}), 256'(0));
    end

    // No grants while calibration is low.
    tick();
    init_calib_complete = 1'b0;
    tick();
    present(1, WR, 28'h888, 128'h66, 16'h2);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("waitcal_no_grant", 256'(req_ready), 256'(0));
      tick();
    end
    expect_req(1, WR, 28'h888, 128'h66, 16'h2);
    init_calib_complete = 1'b1;
    wait_grant(1);
    tick(); tick();
    check_queues_empty("waitcal");

    // Unsolicited read return after reset.
    pulse_reset();
    tick(); tick();
    app_rd_data = DW'(32'hDEAD);
    app_rd_data_valid = 1'b1;
    tick();
    app_rd_data_valid = 1'b0;
    @(negedge clk);
    check("unsolicited_err", 256'({err, rsp_valid}), 256'(3'b100));

    // Illegal command is consumed and flagged.
    tick();
    pulse_reset();
    @(negedge clk);
    check("illegal_err_clear", 256'(err), 256'(0));
    tick(); tick();
    expect_req(0, 3'b111, 28'h999, '0, '0);
    present(0, 3'b111, 28'h999, '0, '0);
    wait_grant(0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("illegal_no_issue", 256'({app_en, busy}), 256'(0));
      tick();
    end
    check("illegal_err", 256'(err), 256'(1));
    check_queues_empty("final");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
